uart_frame_decoder: RTL and testbench
=====================================

// Module: uart_frame_decoder
// PURPOSE
//  Consumes the byte stream from the UART receiver (8-bit DATA + 1-cycle EN strobe) and assembles
//  command frames: SYNC, CMD, LEN, LEN payload bytes, XOR checksum. Validated frames are published
//  on held output registers with a 1-cycle FRAME_VALID strobe for the flight-control command logic.
//  Corrupt, oversized or stalled frames are dropped and reported via FRAME_ERROR/ERR_CODE.
// PARAMETERS
//  MAX_LEN    8       max payload bytes per frame (1..15)
//  TIMEOUT    40000   max CLK cycles between bytes inside a frame before abort
//  SYNC_BYTE  8'hAA   frame start marker
// PORTS
//  CLK          in   1           system clock; everything in this single clock domain
//  RESET_N      in   1           asynchronous, active-low reset
//  RX_DATA      in   8           received byte, valid only when RX_EN=1
//  RX_EN        in   1           1-cycle strobe per received byte
//  CMD          out  8           command id of last good frame
//  LEN          out  4           payload length of last good frame
//  PAYLOAD      out  8*MAX_LEN   payload of last good frame; byte i at [8*i+7:8*i]; unused bytes 0
//  FRAME_VALID  out  1           1-cycle pulse: CMD/LEN/PAYLOAD just updated
//  FRAME_ERROR  out  1           1-cycle pulse: frame dropped
//  ERR_CODE     out  2           cause of last drop: 0 none, 1 checksum, 2 length, 3 timeout
// BEHAVIOUR
//  - Reset (async, RESET_N=0): state IDLE; all outputs 0; shadow buffer, checksum, timer cleared.
//  - States: IDLE, CMD, LEN, PAYLOAD, CHECK. Transitions only on RX_EN, except timeout.
//    IDLE:    RX_EN & RX_DATA==SYNC_BYTE -> CMD; any other byte ignored.
//    CMD:     RX_EN -> capture cmd, csum=RX_DATA -> LEN.
//    LEN:     RX_EN: RX_DATA>MAX_LEN -> error 2, IDLE; ==0 -> CHECK; else -> PAYLOAD, idx=0.
//             csum ^= RX_DATA in all cases.
//    PAYLOAD: RX_EN -> shadow[idx]=RX_DATA, csum^=RX_DATA, idx++; idx==len-1 -> CHECK.
//    CHECK:   RX_EN: RX_DATA==csum -> commit, IDLE; else -> error 1, IDLE.
//  - Checksum = XOR of CMD, LEN and payload bytes; SYNC excluded.
//  - Commit: CMD/LEN/PAYLOAD loaded from shadow (unused bytes zeroed) and FRAME_VALID=1 in the
//    cycle after the checksum byte's RX_EN (latency 1). Outputs hold until the next commit.
//  - Errors: FRAME_ERROR=1 and ERR_CODE updated in the cycle after the detecting event; outputs
//    and ERR_CODE otherwise untouched. ERR_CODE is sticky; only reset clears it.
//  - Timeout: timer cleared in IDLE and on every RX_EN, else increments. Outside IDLE, timer==TIMEOUT
//    -> error 3, IDLE. RX_EN in the same cycle as expiry: the byte wins, no timeout.
//  - SYNC_BYTE appearing inside a frame is data; no resync mid-frame.
//  - FRAME_VALID and FRAME_ERROR are never asserted together.
//  - RX_EN on consecutive cycles is accepted; no back-pressure exists.
//  - Timer width = $clog2(TIMEOUT+1); idx width = $clog2(MAX_LEN); LEN output zero-extended.
// STRUCTURE
//  - Package uart_frame_pkg: state enum (IDLE..CHECK), err_code_t enum (ERR_NONE/CSUM/LEN/TIMEOUT),
//    default SYNC_BYTE constant.
//  - One sub-module: the existing generic counter, instantiated as the inter-byte timeout timer
//    (clear = idle | RX_EN, enable = 1). Payload shadow buffer and commit logic stay inline.
// TESTING
//  1. Bytes AA 01 02 10 20 33 -> one FRAME_VALID; CMD=01 LEN=2 PAYLOAD[15:0]=16'h2010; rest 0.
//  2. AA 05 00 05 -> FRAME_VALID; CMD=05 LEN=0 PAYLOAD=0.
//  3. After 1, AA 01 02 10 20 34 -> FRAME_ERROR, ERR_CODE=1; CMD/LEN/PAYLOAD unchanged from 1.
//  4. AA 07 09 (MAX_LEN=8) -> FRAME_ERROR/ERR_CODE=2 the cycle after 09; next AA starts a new frame.
//  5. AA 01, then TIMEOUT idle cycles -> ERR_CODE=3 exactly once; following frame 1 decodes.
//     Repeat with RX_EN landing on the expiry cycle -> no error.
//  6. Noise 00 55 then frame 1; also RESET_N low during PAYLOAD -> outputs 0 at once, no pulse after.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART command-frame decoder.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHECK
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_CSUM    = 2'd1,
        ERR_LEN     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hAA;

endpackage

// File: rtl/uart_frame_decoder_counter.sv
// Generic up-counter with synchronous clear (priority) and count enable.
module uart_frame_decoder_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             CLEAR,
    input  logic             ENABLE,
    output logic [WIDTH-1:0] COUNT
);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            COUNT <= '0;
        end else if (CLEAR) begin
            COUNT <= '0;
        end else if (ENABLE) begin
            COUNT <= COUNT + 1'b1;
        end
    end

endmodule

// File: rtl/uart_frame_decoder.sv
// Assembles SYNC/CMD/LEN/payload/XOR-checksum frames from a UART byte stream and
// publishes validated frames on held registers; bad or stalled frames are reported.
module uart_frame_decoder
    import uart_frame_pkg::*;
#(
    parameter int unsigned MAX_LEN   = 8,
    parameter int unsigned TIMEOUT   = 40000,
    parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [7:0]           RX_DATA,
    input  logic                 RX_EN,
    output logic [7:0]           CMD,
    output logic [3:0]           LEN,
    output logic [8*MAX_LEN-1:0] PAYLOAD,
    output logic                 FRAME_VALID,
    output logic                 FRAME_ERROR,
    output logic [1:0]           ERR_CODE
);

    localparam int unsigned   TW        = $clog2(TIMEOUT + 1);
    localparam int unsigned   IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    state_t        state, state_nxt;
    logic [TW-1:0] timer;
    logic          timer_clr;
    logic          timeout;
    logic          commit;
    logic          err;
    err_code_t     err_kind;

    logic [7:0]    cmd_sh;
    logic [3:0]    len_sh;
    logic [7:0]    csum;
    logic [IW-1:0] idx;
    logic [7:0]    shadow [MAX_LEN];

    assign timer_clr = (state == ST_IDLE) || RX_EN;

    uart_frame_decoder_counter #(
        .WIDTH(TW)
    ) u_timer (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .CLEAR  (timer_clr),
        .ENABLE (1'b1),
        .COUNT  (timer)
    );

    // A byte arriving on the expiry cycle takes precedence over the timeout.
    assign timeout = (state != ST_IDLE) && !RX_EN && (timer == TIMER_MAX);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        err       = 1'b0;
        err_kind  = ERR_NONE;
        if (timeout) begin
            state_nxt = ST_IDLE;
            err       = 1'b1;
            err_kind  = ERR_TIMEOUT;
        end else if (RX_EN) begin
            case (state)
                ST_IDLE: begin
                    if (RX_DATA == SYNC_BYTE) state_nxt = ST_CMD;
                end
                ST_CMD: state_nxt = ST_LEN;
                ST_LEN: begin
                    if (RX_DATA > MAX_LEN_B) begin
                        state_nxt = ST_IDLE;
                        err       = 1'b1;
                        err_kind  = ERR_LEN;
                    end else if (RX_DATA == 8'd0) begin
                        state_nxt = ST_CHECK;
                    end else begin
                        state_nxt = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (4'(idx) == len_sh - 4'd1) state_nxt = ST_CHECK;
                end
                ST_CHECK: begin
                    state_nxt = ST_IDLE;
                    if (RX_DATA == csum) begin
                        commit = 1'b1;
                    end else begin
                        err      = 1'b1;
                        err_kind = ERR_CSUM;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cmd_sh      <= '0;
            len_sh      <= '0;
            csum        <= '0;
            idx         <= '0;
            for (int unsigned i = 0; i < MAX_LEN; i++) shadow[IW'(i)] <= '0;
            CMD         <= '0;
            LEN         <= '0;
            PAYLOAD     <= '0;
            FRAME_VALID <= 1'b0;
            FRAME_ERROR <= 1'b0;
            ERR_CODE    <= '0;
        end else begin
            FRAME_VALID <= commit;
            FRAME_ERROR <= err;
            if (err) ERR_CODE <= err_kind;
            if (RX_EN) begin
                case (state)
                    ST_CMD: begin
                        cmd_sh <= RX_DATA;
                        csum   <= RX_DATA;
                    end
                    ST_LEN: begin
                        len_sh <= RX_DATA[3:0];
                        csum   <= csum ^ RX_DATA;
                        idx    <= '0;
                    end
                    ST_PAYLOAD: begin
                        shadow[idx] <= RX_DATA;
                        csum        <= csum ^ RX_DATA;
                        idx         <= idx + 1'b1;
                    end
                    default: ;
                endcase
            end
            // Shadow entries past the frame length may be stale from an earlier frame.
            if (commit) begin
                CMD <= cmd_sh;
                LEN <= len_sh;
                for (int unsigned i = 0; i < MAX_LEN; i++) begin
                    PAYLOAD[8*i +: 8] <= (i < 32'(len_sh)) ? shadow[IW'(i)] : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder: frames, checksum/length/timeout errors, reset.
module tb_uart_frame_decoder;

    localparam int unsigned TO = 20;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b1;
    logic [7:0]  RX_DATA = 8'h00;
    logic        RX_EN = 1'b0;
    logic [7:0]  CMD;
    logic [3:0]  LEN;
    logic [63:0] PAYLOAD;
    logic        FRAME_VALID;
    logic        FRAME_ERROR;
    logic [1:0]  ERR_CODE;

    int vectors = 0;
    int miscompares = 0;
    int n_valid = 0;
    int n_err = 0;
    int v0, e0;
    logic [79:0] obs, exp;
    logic [7:0]  seq [$];

    assign obs = {FRAME_VALID, FRAME_ERROR, ERR_CODE, CMD, LEN, PAYLOAD};

    uart_frame_decoder #(
        .MAX_LEN  (8),
        .TIMEOUT  (TO),
        .SYNC_BYTE(8'hAA)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .RX_DATA    (RX_DATA),
        .RX_EN      (RX_EN),
        .CMD        (CMD),
        .LEN        (LEN),
        .PAYLOAD    (PAYLOAD),
        .FRAME_VALID(FRAME_VALID),
        .FRAME_ERROR(FRAME_ERROR),
        .ERR_CODE   (ERR_CODE)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (FRAME_VALID) n_valid++;
        if (FRAME_ERROR) n_err++;
        if (FRAME_VALID && FRAME_ERROR) begin
            miscompares++;
            $display("FAIL pulse_exclusive: valid=%b error=%b required not both", FRAME_VALID, FRAME_ERROR);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_DATA = b;
        RX_EN   = 1'b1;
        @(negedge CLK);
        RX_EN   = 1'b0;
    endtask

    task automatic send_seq();
        foreach (seq[i]) send_byte(seq[i]);
    endtask

    task automatic send_burst();
        foreach (seq[i]) begin
            @(negedge CLK);
            RX_DATA = seq[i];
            RX_EN   = 1'b1;
        end
        @(negedge CLK);
        RX_EN = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(negedge CLK);
        #1;
        v0 = n_valid;
        e0 = n_err;
    endtask

    task automatic test_reset();
        #2 RESET_N = 1'b0;
        repeat (2) @(negedge CLK);
        exp = '0;
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL reset_state: got %h required %h", obs, exp);
        end
        RESET_N = 1'b1;
    endtask

    task automatic test_good_frame();
        settle();
        seq = '{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
        send_seq();
        exp = {1'b1, 1'b0, 2'd0, 8'h01, 4'd2, 64'h2010};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL frame1_commit: got %h required %h", obs, exp);
        end
        @(negedge CLK);
        exp = {1'b0, 1'b0, 2'd0, 8'h01, 4'd2, 64'h2010};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL frame1_hold: got %h required %h", obs, exp);
        end
        @(negedge CLK); #1;
        vectors++;
        if (n_valid - v0 !== 1) begin
            miscompares++;
            $display("FAIL frame1_pulses: got %0d required 1", n_valid - v0);
        end
    endtask

    task automatic test_zero_len();
        settle();
        seq = '{8'hAA, 8'h05, 8'h00, 8'h05};
        send_seq();
        exp = {1'b1, 1'b0, 2'd0, 8'h05, 4'd0, 64'h0};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL zero_len_commit: got %h required %h", obs, exp);
        end
    endtask

    task automatic test_bad_csum();
        settle();
        seq = '{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
        send_seq();
        seq = '{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34};
        send_seq();
        exp = {1'b0, 1'b1, 2'd1, 8'h01, 4'd2, 64'h2010};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL csum_error: got %h required %h", obs, exp);
        end
    endtask

    task automatic test_len_error();
        settle();
        seq = '{8'hAA, 8'h07, 8'h09};
        send_seq();
        exp = {1'b0, 1'b1, 2'd2, 8'h01, 4'd2, 64'h2010};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL len_error: got %h required %h", obs, exp);
        end
        seq = '{8'hAA, 8'h03, 8'h01, 8'h5A, 8'h58};
        send_seq();
        exp = {1'b1, 1'b0, 2'd2, 8'h03, 4'd1, 64'h5A};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL after_len_error: got %h required %h", obs, exp);
        end
        seq = '{8'hAA, 8'h10, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04,
                8'h05, 8'h06, 8'h07, 8'h08, 8'h10};
        send_seq();
        exp = {1'b1, 1'b0, 2'd2, 8'h10, 4'd8, 64'h0807060504030201};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL max_len_frame: got %h required %h", obs, exp);
        end
        seq = '{8'hAA, 8'h02, 8'h02, 8'hAA, 8'h11, 8'hBB};
        send_seq();
        exp = {1'b1, 1'b0, 2'd2, 8'h02, 4'd2, 64'h11AA};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL sync_in_payload: got %h required %h", obs, exp);
        end
    endtask

    task automatic test_timeout();
        settle();
        seq = '{8'hAA, 8'h01};
        send_seq();
        repeat (TO - 1) @(negedge CLK);
        @(negedge CLK);
        exp = {1'b0, 1'b0, 2'd2, 8'h02, 4'd2, 64'h11AA};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL timeout_early: got %h required %h", obs, exp);
        end
        @(negedge CLK);
        exp = {1'b0, 1'b1, 2'd3, 8'h02, 4'd2, 64'h11AA};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL timeout_error: got %h required %h", obs, exp);
        end
        repeat (3) @(negedge CLK);
        #1;
        vectors++;
        if (n_err - e0 !== 1) begin
            miscompares++;
            $display("FAIL timeout_once: got %0d required 1", n_err - e0);
        end
        seq = '{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
        send_seq();
        exp = {1'b1, 1'b0, 2'd3, 8'h01, 4'd2, 64'h2010};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL after_timeout: got %h required %h", obs, exp);
        end
        settle();
        seq = '{8'hAA, 8'h01};
        send_seq();
        repeat (TO - 1) @(negedge CLK);
        send_byte(8'h02);
        exp = {1'b0, 1'b0, 2'd3, 8'h01, 4'd2, 64'h2010};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL expiry_byte_wins: got %h required %h", obs, exp);
        end
        seq = '{8'h10, 8'h20, 8'h33};
        send_seq();
        exp = {1'b1, 1'b0, 2'd3, 8'h01, 4'd2, 64'h2010};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL expiry_frame: got %h required %h", obs, exp);
        end
        repeat (2) @(negedge CLK);
        #1;
        vectors++;
        if (n_err - e0 !== 0) begin
            miscompares++;
            $display("FAIL expiry_no_error: got %0d required 0", n_err - e0);
        end
    endtask

    task automatic test_noise_reset();
        settle();
        seq = '{8'h00, 8'h55, 8'hAA, 8'h03, 8'h01, 8'h5A, 8'h58};
        send_seq();
        exp = {1'b1, 1'b0, 2'd3, 8'h03, 4'd1, 64'h5A};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL noise_then_frame: got %h required %h", obs, exp);
        end
        settle();
        seq = '{8'hAA, 8'h01, 8'h02, 8'h10};
        send_seq();
        RESET_N = 1'b0;
        #1;
        exp = '0;
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL async_reset: got %h required %h", obs, exp);
        end
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        seq = '{8'h20, 8'h33};
        send_seq();
        repeat (3) @(negedge CLK);
        #1;
        vectors++;
        if (obs !== exp || n_valid != v0 || n_err != e0) begin
            miscompares++;
            $display("FAIL post_reset_quiet: got %h pulses v%0d e%0d required %h v0 e0",
                     obs, n_valid - v0, n_err - e0, exp);
        end
    endtask

    task automatic test_back_to_back();
        settle();
        seq = '{8'hAA, 8'h02, 8'h02, 8'hAA, 8'h11, 8'hBB, 8'hAA, 8'h05, 8'h00, 8'h05};
        send_burst();
        exp = {1'b1, 1'b0, 2'd0, 8'h05, 4'd0, 64'h0};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL back_to_back_last: got %h required %h", obs, exp);
        end
        repeat (2) @(negedge CLK);
        #1;
        vectors++;
        if (n_valid - v0 !== 2) begin
            miscompares++;
            $display("FAIL back_to_back_count: got %0d required 2", n_valid - v0);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_zero_len();
        test_bad_csum();
        test_len_error();
        test_timeout();
        test_noise_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
